// File: rtl/screen_pkg.sv
// Shared definitions for the screen write path.
//   COLS / ROWS : geometry of the character memory ring
//   FILL_CHAR   : byte written by clear operations
//   op_e        : command opcodes from the terminal state machine
//   state_e     : write sequencer states
package screen_pkg;

  localparam int COLS = 80;
  localparam int ROWS = 24;
  localparam logic [7:0] FILL_CHAR = 8'h00;

  typedef enum logic [1:0] {
    OP_PUT     = 2'd0,
    OP_CLR_EOL = 2'd1,
    OP_CLR_EOS = 2'd2,
    OP_NOP     = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

endpackage

// File: rtl/screen_write_ctrl_row_base.sv
// Combinational row base address: base = row * 80, built as (row<<6) + (row<<4).
// Ports:
//   row  : 5-bit physical row (0..23)
//   base : 11-bit linear address of column 0 of that row (max 1840)
module row_base (
  input  logic [4:0]  row,
  output logic [10:0] base
);

  logic [10:0] row_w;

  assign row_w = {6'b0, row};
  assign base  = (row_w << 6) + (row_w << 4);

endmodule

// File: rtl/screen_write_ctrl.sv
// Write sequencer for the 80x24 character screen memory (port A, 2048x8).
// Expands PUT / CLR_EOL / CLR_EOS commands into one-cell-per-cycle writes and
// clears the whole screen after every reset.
//
// Handshake: a command transfers on any rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_* and topline are sampled only on that edge.
// cmd_ready is high exactly while the sequencer is idle.
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   cmd_valid/ready    : command handshake
//   cmd_op/x/y/char    : opcode, start column, physical row, PUT character
//   topline            : physical top row, latched as the CLR_EOS stop row
//   mem_addr/wdata/we  : registered memory write port
//   busy               : high while any fill (including the reset clear) runs
//   done               : one-cycle pulse on the final write of a command
// The FSM state is held in state_q (state_e) for hierarchical observation.
module screen_write_ctrl #(
  parameter int         COLS = screen_pkg::COLS,
  parameter int         ROWS = screen_pkg::ROWS,
  parameter logic [7:0] FILL = screen_pkg::FILL_CHAR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [6:0]  cmd_x,
  input  logic [4:0]  cmd_y,
  input  logic [7:0]  cmd_char,
  input  logic [4:0]  topline,
  output logic [10:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        busy,
  output logic        done
);

  import screen_pkg::*;

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  state_e      state_q;
  logic [6:0]  col_q;       // column of the cell currently on the write port
  logic [4:0]  row_q;       // row of the cell currently on the write port
  logic [4:0]  stop_row_q;
  logic        eos_q;
  logic        init_q;      // set for the reset clear, which never pulses done

  logic        accept;
  logic        in_range;
  op_e         op;
  logic [4:0]  next_row;
  logic [4:0]  cmd_next_row;
  logic [4:0]  base_row;
  logic [10:0] base;
  logic        first_is_last;
  logic        step_is_last;

  assign accept   = cmd_valid && cmd_ready;
  assign in_range = (cmd_x <= LAST_COL) && (cmd_y <= LAST_ROW);
  assign op       = op_e'(cmd_op);

  // mod-ROWS row increments for the running fill and for a newly accepted command
  assign next_row     = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
  assign cmd_next_row = (cmd_y == LAST_ROW) ? 5'd0 : cmd_y + 5'd1;

  // One multiplier serves both paths: the command row while idle, the
  // following row while filling (row reload, including the 23 -> 0 wrap).
  assign base_row = (state_q == ST_IDLE) ? cmd_y : next_row;

  row_base u_row_base (
    .row  (base_row),
    .base (base)
  );

  // The first cell of a clear is also its last when it sits in the final
  // column and the clear does not continue onto another row.
  assign first_is_last = (cmd_x == LAST_COL) &&
                         !((op == OP_CLR_EOS) && (cmd_next_row != topline));

  // Stepping along a row: the new cell ends the command if it is the final
  // column and the fill will not move on to another row.
  assign step_is_last = ((col_q + 7'd1) == LAST_COL) &&
                        !(eos_q && (next_row != stop_row_q)) && !init_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FILL;
      col_q      <= 7'd0;
      row_q      <= 5'd0;
      stop_row_q <= 5'd0;
      eos_q      <= 1'b1;
      init_q     <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= 11'd0;
      mem_wdata  <= 8'h00;
      done       <= 1'b0;
      busy       <= 1'b1;
      cmd_ready  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mem_we <= 1'b0;
          done   <= 1'b0;
          if (accept) begin
            case (op)
              OP_PUT: begin
                done <= 1'b1;
                if (in_range) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= base + {4'b0, cmd_x};
                  mem_wdata <= cmd_char;
                end
              end
              OP_CLR_EOL, OP_CLR_EOS: begin
                if (in_range) begin
                  state_q    <= ST_FILL;
                  col_q      <= cmd_x;
                  row_q      <= cmd_y;
                  eos_q      <= (op == OP_CLR_EOS);
                  stop_row_q <= topline;
                  init_q     <= 1'b0;
                  mem_we     <= 1'b1;
                  mem_addr   <= base + {4'b0, cmd_x};
                  mem_wdata  <= FILL;
                  done       <= first_is_last;
                  busy       <= 1'b1;
                  cmd_ready  <= 1'b0;
                end else begin
                  done <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end

        ST_FILL: begin
          if (!mem_we) begin
            // Only reached straight after reset: cell (0,0) at address 0 is
            // already loaded, so just start writing it.
            mem_we    <= 1'b1;
            mem_wdata <= FILL;
            done      <= 1'b0;
          end else if (col_q != LAST_COL) begin
            col_q    <= col_q + 7'd1;
            mem_addr <= mem_addr + 11'd1;
            done     <= step_is_last;
          end else if (eos_q && (next_row != stop_row_q)) begin
            row_q    <= next_row;
            col_q    <= 7'd0;
            mem_addr <= base;
            // column 0 is never the final column, so a fresh row never ends
            done     <= 1'b0;
          end else begin
            state_q   <= ST_IDLE;
            mem_we    <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            init_q    <= 1'b0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_write_ctrl.sv
// Directed bench for screen_write_ctrl. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_screen_write_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [6:0]  cmd_x;
  logic [4:0]  cmd_y;
  logic [7:0]  cmd_char;
  logic [4:0]  topline;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];

  screen_write_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_char  (cmd_char),
    .topline   (topline),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .busy      (busy),
    .done      (done)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // {busy, cmd_ready, done, mem_we, mem_wdata, mem_addr}
  function automatic logic [31:0] obs_all();
    return {9'd0, busy, cmd_ready, done, mem_we, mem_wdata, mem_addr};
  endfunction

  function automatic logic [31:0] ev(input logic b, input logic r, input logic d,
                                     input logic w, input logic [7:0] data,
                                     input logic [10:0] addr);
    return {9'd0, b, r, d, w, data, addr};
  endfunction

  // {busy, cmd_ready, done, mem_we}
  function automatic logic [31:0] obs_ctrl();
    return {28'd0, busy, cmd_ready, done, mem_we};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // driver: present one command for exactly one accepting edge
  task automatic issue(input string tag, input logic [1:0] op, input logic [6:0] x,
                       input logic [4:0] y, input logic [7:0] ch, input logic [4:0] top);
    check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_op    = op;
    cmd_x     = x;
    cmd_y     = y;
    cmd_char  = ch;
    topline   = top;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // consume exp_q as a contiguous run of fill writes, then expect idle
  task automatic run_fill(input string tag);
    logic [10:0] a;
    while (exp_q.size() > 0) begin
      a = exp_q.pop_front();
      check(tag, obs_all(), ev(1'b1, 1'b0, (exp_q.size() == 0), 1'b1, 8'h00, a));
      @(negedge clk);
    end
    check({tag, "_idle"}, obs_ctrl(), 32'b0100);
  endtask

  // release reset and follow the full-screen clear
  task automatic release_and_clear(input string tag);
    reset = 1'b0;
    for (int i = 0; i < 1920; i++) begin
      @(negedge clk);
      check(tag, obs_all(), ev(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 11'(i)));
    end
    @(negedge clk);
    check({tag, "_ready"}, obs_ctrl(), 32'b0100);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_x     = 7'd0;
    cmd_y     = 5'd0;
    cmd_char  = 8'h00;
    topline   = 5'd0;

    repeat (3) @(negedge clk);
    check("reset_state", obs_all(), ev(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 11'd0));
    release_and_clear("reset_clear");

    // three back-to-back PUTs of 'A' at (5,2) -> address 165
    check("put_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_op = 2'd0; cmd_x = 7'd5; cmd_y = 5'd2; cmd_char = 8'h41;
    cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("put_b2b", obs_all(), ev(1'b0, 1'b1, 1'b1, 1'b1, 8'h41, 11'd165));
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    check("put_end", obs_ctrl(), 32'b0100);

    // CLR_EOL from (70,23): 1910..1919
    issue("clr_eol_start", 2'd1, 7'd70, 5'd23, 8'h00, 5'd0);
    for (int a = 1910; a <= 1919; a++) exp_q.push_back(11'(a));
    run_fill("clr_eol");

    // CLR_EOS from (78,22), top 3: 1838..1919 then 0..239; topline moves mid-fill
    issue("clr_eos_start", 2'd2, 7'd78, 5'd22, 8'h00, 5'd3);
    topline = 5'd1;
    for (int a = 1838; a <= 1919; a++) exp_q.push_back(11'(a));
    for (int a = 0; a <= 239; a++) exp_q.push_back(11'(a));
    run_fill("clr_eos_wrap");

    // CLR_EOS from (0,4), top 5: row 4 only
    issue("clr_eos1_start", 2'd2, 7'd0, 5'd4, 8'h00, 5'd5);
    for (int a = 320; a <= 399; a++) exp_q.push_back(11'(a));
    run_fill("clr_eos_one_row");

    // out-of-range PUT x=80: done only
    issue("put_oor_start", 2'd0, 7'd80, 5'd0, 8'h55, 5'd0);
    check("put_oor", obs_ctrl(), 32'b0110);
    @(negedge clk);
    check("put_oor_after", obs_ctrl(), 32'b0100);

    // out-of-range CLR_EOL y=24: done only, no fill
    issue("eol_oor_start", 2'd1, 7'd0, 5'd24, 8'h00, 5'd0);
    check("eol_oor", obs_ctrl(), 32'b0110);
    @(negedge clk);
    check("eol_oor_after", obs_ctrl(), 32'b0100);

    // reserved op: nothing at all
    issue("nop_start", 2'd3, 7'd1, 5'd1, 8'h66, 5'd0);
    check("nop", obs_ctrl(), 32'b0100);
    @(negedge clk);
    check("nop_after", obs_ctrl(), 32'b0100);

    // PUT at the last cell (79,23) -> 1919
    issue("put_last_start", 2'd0, 7'd79, 5'd23, 8'h5A, 5'd0);
    check("put_last", obs_all(), ev(1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 11'd1919));

    // reset on the 17th cycle of a CLR_EOL of row 10 (800..879)
    @(negedge clk);
    issue("abort_start", 2'd1, 7'd0, 5'd10, 8'h00, 5'd0);
    for (int i = 0; i < 16; i++) begin
      check("abort_fill", obs_all(), ev(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 11'(800 + i)));
      @(negedge clk);
    end
    check("abort_fill17", obs_all(), ev(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 11'd816));
    reset = 1'b1;
    @(negedge clk);
    check("abort_reset", obs_all(), ev(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 11'd0));
    @(negedge clk);
    check("abort_hold", obs_all(), ev(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 11'd0));
    release_and_clear("abort_clear");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
